// File: rtl/jam_cost_table.sv
// ============================================================================
// Module   : jam_cost_table
// Purpose  : Cost-matrix store and load sequencer for the JAM job-assignment
//            engine. Receives the 8x8 matrix of 7-bit costs as a 64-entry
//            valid/ready stream, holds JAM in reset until the matrix is
//            complete, then serves (W, J) lookups combinationally on Cost.
//            A Start pulse reloads the matrix and puts JAM back in reset.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK      in   1  clock, rising edge
//   RST      in   1  asynchronous active-high reset
//   Start    in   1  one-cycle pulse, begins/restarts a matrix load
//   InValid  in   1  stream entry present
//   InData   in   8  [6:0] cost, [7] even-parity bit
//   InReady  out  1  entry accepted this cycle when InValid is also high
//   W        in   3  worker index from JAM
//   J        in   3  job index from JAM
//   Cost     out  7  cost of (W, J); 0 while the matrix is not loaded
//   JamRst   out  1  reset for JAM, high while the matrix is not loaded
//   Loaded   out  1  matrix complete and servable
//   ParErr   out  1  sticky parity error
// ----------------------------------------------------------------------------
// Configuration
//   JAM_COST_PARITY_EN : when defined, every accepted entry is checked for
//   even parity over InData[7:0]; an odd entry is discarded, the sequencer
//   parks in ERR and ParErr is raised until the next Start. When undefined,
//   InData[7] is ignored and ParErr is tied low.
// ============================================================================
`default_nettype none

module jam_cost_table (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic       InValid,
  input  logic [7:0] InData,
  output logic       InReady,
  input  logic [2:0] W,
  input  logic [2:0] J,
  output logic [6:0] Cost,
  output logic       JamRst,
  output logic       Loaded,
  output logic       ParErr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [5:0] c_LAST_IDX = 6'd63;

  state_t     r_state;
  logic [5:0] r_cnt;
  logic       r_in_ready;
  logic       r_jam_rst;
  logic       r_loaded;
  logic [6:0] r_mem [0:63];

  logic       w_accept;
  logic       w_write;

  // Start takes priority over the stream: an entry presented in the same
  // cycle as Start is dropped, so a restart always begins from address 0.
  assign w_accept = InValid & r_in_ready & ~Start;

`ifdef JAM_COST_PARITY_EN
  logic r_par_err;
  logic w_par_bad;

  // Even parity over all eight bits: odd reduction XOR means corrupted.
  assign w_par_bad = ^InData;
  assign w_write   = w_accept & ~w_par_bad;
  assign ParErr    = r_par_err;
`else
  logic w_unused_par;

  assign w_unused_par = InData[7];
  assign w_write      = w_accept;
  assign ParErr       = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Sequencer. Outputs are registered alongside the state so that JamRst and
  // Loaded change on the same edge as the state transition.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= 6'd0;
      r_in_ready <= 1'b0;
      r_jam_rst  <= 1'b1;
      r_loaded   <= 1'b0;
`ifdef JAM_COST_PARITY_EN
      r_par_err  <= 1'b0;
`endif
    end else if (Start) begin
      // Any state restarts the load; JAM goes back into reset on this edge.
      r_state    <= S_LOAD;
      r_cnt      <= 6'd0;
      r_in_ready <= 1'b1;
      r_jam_rst  <= 1'b1;
      r_loaded   <= 1'b0;
`ifdef JAM_COST_PARITY_EN
      r_par_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
`ifdef JAM_COST_PARITY_EN
            if (w_par_bad) begin
              r_state    <= S_ERR;
              r_in_ready <= 1'b0;
              r_par_err  <= 1'b1;
            end else
`endif
            begin
              r_cnt <= r_cnt + 6'd1;
              if (r_cnt == c_LAST_IDX) begin
                // Last entry lands on this edge; JAM may leave reset.
                r_state    <= S_READY;
                r_in_ready <= 1'b0;
                r_loaded   <= 1'b1;
                r_jam_rst  <= 1'b0;
              end
            end
          end
        end
        default: begin
          // IDLE, READY and ERR only leave on Start, handled above.
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Cost storage. Not reset: contents are only visible once a complete load
  // has overwritten every entry.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (w_write) begin
      r_mem[r_cnt] <= InData[6:0];
    end
  end

  assign InReady = r_in_ready;
  assign JamRst  = r_jam_rst;
  assign Loaded  = r_loaded;
  assign Cost    = r_loaded ? r_mem[{W, J}] : 7'd0;

endmodule

`default_nettype wire

// File: doc/jam_cost_table.md
# jam_cost_table

Cost-matrix store and sequencer that sits directly upstream of the JAM job-assignment engine. It accepts the 8×8 worker/job cost matrix as a 64-entry valid/ready stream and holds the JAM engine in reset until loading completes. It then answers the engine's (W, J) lookups combinationally on Cost. A Start pulse reloads the matrix and restarts the engine.

## Interface
Parameters:
- none; the matrix is fixed at 8×8, 7-bit costs.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Start  in  1  one-cycle pulse; begins or restarts a matrix load.
- InValid  in  1  stream entry present.
- InData  in  8  [6:0] cost; [7] even-parity bit, used only when the parity check is compiled in.
- InReady  out  1  block accepts an entry this cycle.
- W  in  3  worker index from JAM.
- J  in  3  job index from JAM.
- Cost  out  7  cost of (W, J), combinational.
- JamRst  out  1  drives JAM's RST; high while the matrix is not loaded.
- Loaded  out  1  matrix complete and servable.
- ParErr  out  1  sticky parity error.

## Operation
- Storage: 64×7 array, address {W,J}; entry k goes to address k (row-major: W=k[5:3], J=k[2:0]). The array is not reset.
- Load counter: 6 bits, cleared on entering LOAD, incremented per accepted entry.
- An entry is accepted on a rising edge where InValid & InReady.
- FSM states:
  - IDLE (reset state): InReady=0, JamRst=1, Loaded=0. Start → LOAD.
  - LOAD: InReady=1. Each acceptance writes the array. Acceptance with counter=63 → READY. Start → LOAD (counter cleared; that cycle's entry dropped).
  - READY: InReady=0, Loaded=1, JamRst=0. Start → LOAD; JamRst=1 and Loaded=0 from the next edge.
  - ERR: InReady=0, JamRst=1, Loaded=0, ParErr=1. Start → LOAD, clearing ParErr.
- Cost = array[{W,J}] when Loaded=1, else 7'd0.
- Start in IDLE/ERR/READY with InValid=1 the same cycle: no acceptance, because InReady=0.

## Timing
- Reset values: InReady=0, JamRst=1, Loaded=0, ParErr=0, state IDLE, counter 0.
- All outputs except Cost are registered, decoded from FSM state.
- Start sampled at edge n → InReady=1 from edge n.
- First entry can be accepted at edge n+1.
- With no stalls, 64 entries are accepted at edges n+1..n+64. At edge n+64, Loaded→1 and JamRst→0.
- JAM leaves reset in the cycle after n+64.
- Cost follows W/J with zero cycles of latency, so JAM's CALC-cycle sampling of Cost sees the entry for W/J registered in its RECV cycle.
- Stalls (InValid=0) hold the counter. There is no timeout.
- RST mid-load: immediate return to IDLE; the partial array contents are irrelevant because Loaded=0.

## Configuration
- Macro: JAM_COST_PARITY_EN.
- Defined:
  - Each accepted entry is checked for even parity over InData[7:0].
  - An odd entry is not written. The FSM goes to ERR at that edge and ParErr→1.
- Undefined:
  - InData[7] is ignored.
  - ParErr is constant 0.
  - ERR is unreachable; no parity logic is synthesised.

## Test plan
- Reset, then Start, then stream entries cost=(W*8+J)%100 with no stalls → Loaded rises exactly 64 cycles after Start; Cost at W=3,J=5 reads 29; JamRst falls with Loaded.
- Same stream with InValid deasserted on every other cycle → 64 acceptances over 128 cycles; counter holds during gaps; final array is identical to the unstalled case.
- Start pulse after 20 accepted entries, then a full 64-entry stream of 7'd9 → array all 9; first 20 old values fully overwritten; JamRst stays 1 until the new load completes.
- JAM_COST_PARITY_EN defined, entry 10 sent as 8'h01 (odd parity) → ParErr=1, state ERR, InReady=0, JamRst=1; Start clears ParErr and reopens LOAD.
- Loaded table driving a real JAM instance with the standard matrix → JAM Valid asserts with MinCost/MatchCount equal to the golden values; Cost is never 0 while Loaded=1 for nonzero entries.
- RST asserted asynchronously mid-stream (entry 40) → InReady, Loaded, ParErr = 0 and JamRst=1 immediately; no writes until the next Start.
